// File: rtl/weights_sram_loader.sv
// Expands a compressed weight byte stream (pruned lanes omitted) into 32-bit words
// and writes words 0..N-1 into the weight memory through a single write port.
module weights_sram_loader #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   num_words,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   n_q, n_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [1:0]    lane_q, lane_d;
    logic          ph2_q, ph2_d;
    logic [1:0]    ph3_q, ph3_d;
    logic [1:0]    ph4_q, ph4_d;
    logic [31:0]   buf_q, buf_d;
    logic          in_ready_q, in_ready_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [3:0]    keep;
    logic [1:0]    next_lane;
    logic          next_found;
    logic [31:0]   buf_ins;
    logic          accept;
    logic          last_word;

    function automatic logic [31:0] zero_pruned(input logic [31:0] w, input logic [3:0] k);
        return w & {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
    endfunction

    // Lane k of word i is kept when i % (k+1) == 0; the phase counters hold i % k.
    assign keep      = {ph4_q == 2'd0, ph3_q == 2'd0, ph2_q == 1'b0, 1'b1};
    assign accept    = in_valid && in_ready_q;
    assign last_word = ({1'b0, idx_q} == (n_q - 1'b1));

    always_comb begin
        next_lane  = lane_q;
        next_found = 1'b0;
        for (int l = 3; l >= 1; l--) begin
            if (l > int'(lane_q) && keep[l]) begin
                next_lane  = 2'(l);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        buf_ins = buf_q;
        buf_ins[{lane_q, 3'b000} +: 8] = in_data;
    end

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        idx_d       = idx_q;
        lane_d      = lane_q;
        ph2_d       = ph2_q;
        ph3_d       = ph3_q;
        ph4_d       = ph4_q;
        buf_d       = buf_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_words == '0) begin
                        state_d = DONE;
                    end else begin
                        n_d     = (num_words > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_words;
                        idx_d   = '0;
                        lane_d  = '0;
                        ph2_d   = 1'b0;
                        ph3_d   = '0;
                        ph4_d   = '0;
                        buf_d   = '0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (accept) begin
                    buf_d = buf_ins;
                    if (next_found) begin
                        lane_d = next_lane;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = idx_q;
                        mem_wdata_d = zero_pruned(buf_ins, keep);
                        state_d     = WRITE;
                    end
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    lane_d  = '0;
                    ph2_d   = ~ph2_q;
                    ph3_d   = (ph3_q == 2'd2) ? 2'd0 : ph3_q + 2'd1;
                    ph4_d   = ph4_q + 2'd1;
                    buf_d   = '0;
                    state_d = FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == FETCH);
        busy_d     = (state_d != IDLE);
        done_d     = (state_q == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            idx_q       <= '0;
            lane_q      <= '0;
            ph2_q       <= 1'b0;
            ph3_q       <= '0;
            ph4_q       <= '0;
            buf_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            ph2_q       <= ph2_d;
            ph3_q       <= ph3_d;
            ph4_q       <= ph4_d;
            buf_q       <= buf_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
